// File: rtl/chained_xor_cipher_engine.sv
// chained_xor_cipher_engine
// Byte-serial chained-XOR cipher. A DATA_W-bit word and key are accepted
// under valid/ready, one byte lane is processed per clock (LSB lane first),
// and the finished word is offered on a valid/ready output port.
//
// Lane i result:  r = prev ^ d[i] ^ k[i]
//   encrypt: the chain byte for the next lane is r (the ciphertext byte)
//   decrypt: the chain byte for the next lane is d[i] (the ciphertext byte)
// Because both directions chain on the ciphertext byte, the same datapath
// performs encrypt and decrypt.
//
// Optional build macro: CHAINED_XOR_CIPHER_CHAIN_EN
//   defined   : the chain byte carries over from one word to the next, and
//               an extra input chain_clr reloads it with IV while idle
//               (chain_clr wins over a simultaneous acceptance).
//   undefined : every word starts its chain from IV; no chain_clr port.

module chained_xor_cipher_engine #(
   parameter int         DATA_W = 32,
   parameter logic [7:0] IV     = 8'h9B
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] in_key,
   input  logic              in_mode,
`ifdef CHAINED_XOR_CIPHER_CHAIN_EN
   input  logic              chain_clr,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

   localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_r;
   logic [IDX_W-1:0]    idx_r;
   logic [7:0]          prev_r;
   logic [DATA_W-1:0]   data_r;
   logic [DATA_W-1:0]   key_r;
   logic                mode_r;
   logic [DATA_W-1:0]   out_data_r;
   logic                out_valid_r;
   logic                in_ready_r;
   logic                busy_r;

   logic [IDX_W+2:0]    lane_sel_s;
   logic [7:0]          lane_d_s;
   logic [7:0]          lane_k_s;
   logic [7:0]          lane_res_s;
   logic [7:0]          chain_next_s;
   logic                last_lane_s;
   logic                accept_s;
   logic                reload_iv_s;

   // Per-lane datapath: select the current byte lane and form its result and next chain byte.
   always_comb begin
      lane_sel_s   = {idx_r, 3'b000};
      lane_d_s     = data_r[lane_sel_s +: 8];
      lane_k_s     = key_r[lane_sel_s +: 8];
      lane_res_s   = prev_r ^ lane_d_s ^ lane_k_s;
      last_lane_s  = (idx_r == IDX_LAST);
      if (mode_r) begin
         chain_next_s = lane_d_s;
      end else begin
         chain_next_s = lane_res_s;
      end
   end

   // Acceptance and chain-seed control; in_ready_r is only ever high in IDLE.
   always_comb begin
      accept_s = in_valid & in_ready_r;
`ifdef CHAINED_XOR_CIPHER_CHAIN_EN
      reload_iv_s = chain_clr;
`else
      reload_iv_s = accept_s;
`endif
   end

   // Control FSM with registered handshake outputs and the result word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         idx_r       <= IDX_ZERO;
         prev_r      <= IV;
         data_r      <= {DATA_W{1'b0}};
         key_r       <= {DATA_W{1'b0}};
         mode_r      <= 1'b0;
         out_data_r  <= {DATA_W{1'b0}};
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // A chain reload here also covers a word accepted on this edge.
               if (reload_iv_s) begin
                  prev_r <= IV;
               end else begin
                  prev_r <= prev_r;
               end
               if (accept_s) begin
                  data_r     <= in_data;
                  key_r      <= in_key;
                  mode_r     <= in_mode;
                  idx_r      <= IDX_ZERO;
                  out_data_r <= {DATA_W{1'b0}};
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= ST_RUN;
               end else begin
                  state_r    <= ST_IDLE;
               end
            end

            ST_RUN: begin
               out_data_r[lane_sel_s +: 8] <= lane_res_s;
               prev_r                      <= chain_next_s;
               if (last_lane_s) begin
                  // idx stays on the last lane; it never wraps inside a word.
                  out_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
               end else begin
                  idx_r       <= idx_r + IDX_ONE;
               end
            end

            ST_DONE: begin
               // Hold the result until downstream takes it; inputs are ignored.
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
                  state_r     <= ST_IDLE;
               end else begin
                  state_r     <= ST_DONE;
               end
            end

            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               busy_r      <= 1'b0;
               idx_r       <= IDX_ZERO;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign busy      = busy_r;

endmodule
